// File: rtl/wrr_pop_scheduler.sv
// Weighted round-robin pop scheduler: drains four class FIFOs into one destination FIFO,
// giving each class weight+1 consecutive pops per turn.
module wrr_pop_scheduler #(
  parameter int unsigned DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty_0,
  input  logic                  empty_1,
  input  logic                  empty_2,
  input  logic                  empty_3,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            weight_0,
  input  logic [1:0]            weight_1,
  input  logic [1:0]            weight_2,
  input  logic [1:0]            weight_3,
  input  logic                  dest_almost_full,
  output logic                  pop_0,
  output logic                  pop_1,
  output logic                  pop_2,
  output logic                  pop_3,
  output logic                  push,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            grant_id,
  output logic                  busy
);

  typedef enum logic [0:0] {StIdle, StServe} state_e;

  state_e                state_q;
  logic [1:0]            ptr_q;
  logic [2:0]            credit_q;
  logic                  push_q;
  logic [DATA_WIDTH-1:0] data_out_q;

  logic [3:0] nonempty;
  logic [1:0] weight [4];
  logic [3:0] pop_vec;
  logic       any_ne;
  logic       any_pop;
  logic [1:0] next_ptr;
  logic [2:0] next_credit;

  // First non-empty class scanning start, start+1, ... (mod 4).
  function automatic logic [1:0] rotate(input logic [1:0] start, input logic [3:0] ne);
    logic [1:0] res;
    logic [1:0] idx;
    res = start;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (ne[idx]) res = idx;
    end
    return res;
  endfunction

  assign nonempty    = ~{empty_3, empty_2, empty_1, empty_0};
  assign weight[0]   = weight_0;
  assign weight[1]   = weight_1;
  assign weight[2]   = weight_2;
  assign weight[3]   = weight_3;
  assign any_ne      = |nonempty;
  assign next_ptr    = rotate(ptr_q + 2'd1, nonempty);
  assign next_credit = {1'b0, weight[next_ptr]} + 3'd1;

  always_comb begin
    pop_vec = '0;
    if (state_q == StServe && nonempty[ptr_q] && !dest_almost_full && credit_q != 3'd0 &&
        !reset) begin
      pop_vec[ptr_q] = 1'b1;
    end
  end

  assign any_pop  = |pop_vec;
  assign pop_0    = pop_vec[0];
  assign pop_1    = pop_vec[1];
  assign pop_2    = pop_vec[2];
  assign pop_3    = pop_vec[3];
  assign push     = push_q;
  assign data_out = data_out_q;
  assign grant_id = ptr_q;
  assign busy     = (state_q == StServe);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ptr_q      <= 2'd3;
      credit_q   <= 3'd0;
      push_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      push_q <= any_pop;
      if (any_pop) data_out_q <= data_in;
      unique case (state_q)
        StIdle: begin
          if (any_ne && !dest_almost_full) begin
            state_q  <= StServe;
            ptr_q    <= next_ptr;
            credit_q <= next_credit;
          end
        end
        StServe: begin
          if (!dest_almost_full) begin
            if (any_pop && credit_q > 3'd1) begin
              credit_q <= credit_q - 3'd1;
            end else if (any_ne) begin
              // Last credit spent or head class ran dry: hand over to the next class.
              ptr_q    <= next_ptr;
              credit_q <= next_credit;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
